bcd_entry_reg: RTL and testbench

Parametrised keypad-entry register for the calculator datapath. It accumulates BCD digits right-justified, and supports backspace, clear, sign toggle and decimal point. It can also recall a stored word from memory with validation. Its output feeds the 7-segment display driver and the operand path; blank nibbles render dark.

---
 rtl/bcd_pkg.sv | 9 +
 rtl/bcd_mem_scan.sv | 34 +++
 rtl/bcd_entry_reg.sv | 136 +++++++++++++
 tb/tb_bcd_entry_reg.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared nibble codes, entry state encoding and digit test
package bcd_pkg;
  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [3:0] MINUS = 4'hE;
  typedef enum logic [1:0] {EMPTY, ENTRY, FULL, RECALLED} state_t;
  function automatic logic is_bcd(input logic [3:0] nibble);
    return nibble <= 4'd9;
  endfunction
endpackage

// File: rtl/bcd_mem_scan.sv
// bcd_mem_scan: validates a stored display word and extracts its sign and digit count
module bcd_mem_scan
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter logic [3:0] BLANK = bcd_pkg::BLANK,
  parameter logic [3:0] MINUS = bcd_pkg::MINUS
) (
  input  logic [4*DIGITS-1:0]         mem,
  output logic                        valid,
  output logic                        negative,
  output logic [$clog2(DIGITS+1)-1:0] count
);
  localparam int CW = $clog2(DIGITS+1);
  logic [3:0] nib;
  always_comb begin
    valid = 1'b1;
    negative = 1'b0;
    count = '0;
    nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = mem[4*i +: 4];
      if (is_bcd(nib)) begin
        count = CW'(i + 1);
        valid = valid && !negative;
      end else if (nib == MINUS) begin
        valid = valid && !negative;
        negative = 1'b1;
      end else if (nib != BLANK) begin
        valid = 1'b0;
      end
    end
  end
endmodule

// File: rtl/bcd_entry_reg.sv
// bcd_entry_reg: keypad BCD entry register with edit commands and validated memory recall
module bcd_entry_reg
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter logic [3:0] BLANK = bcd_pkg::BLANK,
  parameter logic [3:0] MINUS = bcd_pkg::MINUS
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [3:0]                  digit,
  input  logic                        load,
  input  logic                        bksp,
  input  logic                        clear,
  input  logic                        neg_toggle,
  input  logic                        dp_set,
  input  logic                        load_mem,
  input  logic [4*DIGITS-1:0]         mem,
  output logic [4*DIGITS-1:0]         bcdreg,
  output logic [$clog2(DIGITS+1)-1:0] count,
  output logic                        negative,
  output logic                        dp_valid,
  output logic [$clog2(DIGITS+1)-1:0] dp_pos,
  output logic                        full,
  output logic                        error
);
  localparam int W = 4*DIGITS;
  localparam int CW = $clog2(DIGITS+1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] MAXC = CW'(DIGITS);
  localparam logic [W-1:0] ALL_BLANK = {DIGITS{BLANK}};
  state_t state, state_n;
  logic [W-1:0] store, store_n;
  logic [CW-1:0] count_n, dp_pos_n, cap, cap_n, scan_count;
  logic negative_n, dp_valid_n, error_n, hold, recall, scan_valid, scan_neg;
  bcd_mem_scan #(.DIGITS(DIGITS), .BLANK(BLANK), .MINUS(MINUS)) u_scan (
    .mem(mem),
    .valid(scan_valid),
    .negative(scan_neg),
    .count(scan_count)
  );
  assign cap = negative ? MAXC - ONE : MAXC;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      store <= ALL_BLANK;
      count <= '0;
      negative <= 1'b0;
      dp_valid <= 1'b0;
      dp_pos <= '0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      store <= store_n;
      count <= count_n;
      negative <= negative_n;
      dp_valid <= dp_valid_n;
      dp_pos <= dp_pos_n;
      error <= error_n;
    end
  end
  always_comb begin
    store_n = store;
    count_n = count;
    negative_n = negative;
    dp_valid_n = dp_valid;
    dp_pos_n = dp_pos;
    error_n = 1'b0;
    hold = 1'b0;
    recall = 1'b0;
    if (clear) begin
      store_n = ALL_BLANK;
      count_n = '0;
      negative_n = 1'b0;
      dp_valid_n = 1'b0;
      dp_pos_n = '0;
    end else if (load_mem) begin
      if (!scan_valid) error_n = 1'b1;
      else begin
        store_n = mem;
        count_n = scan_count;
        negative_n = scan_neg;
        dp_valid_n = 1'b0;
        dp_pos_n = '0;
        recall = mem != ALL_BLANK;
      end
    end else if (bksp) begin
      if (dp_valid && dp_pos == '0) dp_valid_n = 1'b0;
      else if (count != '0) begin
        store_n = {BLANK, store[W-1:4]};
        count_n = count - ONE;
        dp_pos_n = dp_valid ? dp_pos - ONE : dp_pos;
        negative_n = negative && count != ONE;
      end
    end else if (neg_toggle) begin
      if (count != '0 && !negative && count == MAXC) error_n = 1'b1;
      else if (count != '0) negative_n = !negative;
    end else if (dp_set) begin
      if (dp_valid || count == cap) error_n = 1'b1;
      else begin
        if (count == '0) begin
          store_n = {store[W-5:0], 4'd0};
          count_n = ONE;
        end
        dp_valid_n = 1'b1;
        dp_pos_n = '0;
      end
    end else if (load) begin
      if (!is_bcd(digit)) error_n = 1'b1;
      else if (state == RECALLED) begin
        store_n = {{(DIGITS-1){BLANK}}, digit};
        count_n = ONE;
        negative_n = 1'b0;
        dp_valid_n = 1'b0;
        dp_pos_n = '0;
      end else if (count == cap) error_n = 1'b1;
      else if (digit != 4'd0 || count != '0 || dp_valid) begin
        store_n = {store[W-5:0], digit};
        count_n = count + ONE;
        dp_pos_n = dp_valid ? dp_pos + ONE : dp_pos;
      end
    end else begin
      hold = 1'b1;
    end
    cap_n = negative_n ? MAXC - ONE : MAXC;
    state_n = (hold || error_n) ? state : recall ? RECALLED :
              count_n == '0 ? EMPTY : count_n == cap_n ? FULL : ENTRY;
  end
  always_comb begin
    full = count == cap;
    bcdreg = ALL_BLANK;
    for (int i = 0; i < DIGITS; i++)
      bcdreg[4*i +: 4] = CW'(i) < count ? store[4*i +: 4] :
                         (CW'(i) == count && negative) ? MINUS : BLANK;
  end
endmodule

// File: tb/tb_bcd_entry_reg.sv
// tb_bcd_entry_reg: scoreboard bench for the keypad BCD entry register
module tb_bcd_entry_reg;
  typedef struct packed {
    logic [31:0] bcd;
    logic [3:0]  cnt;
    logic        neg;
    logic        dpv;
    logic [3:0]  dpp;
    logic        full;
    logic        err;
  } exp_t;
  localparam logic [5:0] CLR = 6'b100000, MEM = 6'b010000, BKS = 6'b001000,
                         NEG = 6'b000100, DPS = 6'b000010, LD = 6'b000001, IDLE = 6'b0;
  logic clock, reset_n, load, bksp, clear, neg_toggle, dp_set, load_mem;
  logic negative, dp_valid, full, error;
  logic [3:0] digit, count, dp_pos;
  logic [31:0] mem, bcdreg, acc;
  exp_t sb[$];
  string tq[$];
  exp_t e;
  string t;
  int n_chk = 0, n_pass = 0;
  bcd_entry_reg #(.DIGITS(8)) dut (
    .clock(clock), .reset_n(reset_n), .digit(digit), .load(load), .bksp(bksp),
    .clear(clear), .neg_toggle(neg_toggle), .dp_set(dp_set), .load_mem(load_mem),
    .mem(mem), .bcdreg(bcdreg), .count(count), .negative(negative),
    .dp_valid(dp_valid), .dp_pos(dp_pos), .full(full), .error(error)
  );
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic exp_t mk(input logic [31:0] b, input logic [3:0] c, input logic n,
                              input logic dv, input logic [3:0] dp, input logic f, input logic er);
    return '{bcd: b, cnt: c, neg: n, dpv: dv, dpp: dp, full: f, err: er};
  endfunction
  task automatic step(input string tag, input logic [5:0] c, input logic [3:0] d,
                      input logic [31:0] m, input exp_t x);
    @(negedge clock);
    {clear, load_mem, bksp, neg_toggle, dp_set, load} = c;
    digit = d;
    mem = m;
    sb.push_back(x);
    tq.push_back(tag);
  endtask
  always @(posedge clock) begin
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      t = tq.pop_front();
      check({t, "/bcd"}, bcdreg, e.bcd);
      check({t, "/count"}, 32'(count), 32'(e.cnt));
      check({t, "/neg"}, 32'(negative), 32'(e.neg));
      check({t, "/dpv"}, 32'(dp_valid), 32'(e.dpv));
      check({t, "/dpp"}, 32'(dp_pos), 32'(e.dpp));
      check({t, "/full"}, 32'(full), 32'(e.full));
      check({t, "/err"}, 32'(error), 32'(e.err));
    end
  end
  initial begin
    reset_n = 1'b0;
    {clear, load_mem, bksp, neg_toggle, dp_set, load} = IDLE;
    digit = '0;
    mem = '0;
    #2;
    check("rst/bcd", bcdreg, 32'hFFFFFFFF);
    check("rst/count", 32'(count), 32'd0);
    check("rst/err", 32'(error), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step("ld1", LD, 4'd1, '0, mk(32'hFFFFFFF1, 1, 0, 0, 0, 0, 0));
    step("ld2", LD, 4'd2, '0, mk(32'hFFFFFF12, 2, 0, 0, 0, 0, 0));
    step("ld3", LD, 4'd3, '0, mk(32'hFFFFF123, 3, 0, 0, 0, 0, 0));
    step("neg", NEG, 4'd0, '0, mk(32'hFFFFE123, 3, 1, 0, 0, 0, 0));
    step("clr", CLR, 4'd0, '0, mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
    step("dp_ld1", LD, 4'd1, '0, mk(32'hFFFFFFF1, 1, 0, 0, 0, 0, 0));
    step("dp_set", DPS, 4'd0, '0, mk(32'hFFFFFFF1, 1, 0, 1, 0, 0, 0));
    step("dp_ld5", LD, 4'd5, '0, mk(32'hFFFFFF15, 2, 0, 1, 1, 0, 0));
    step("dp_bk1", BKS, 4'd0, '0, mk(32'hFFFFFFF1, 1, 0, 1, 0, 0, 0));
    step("dp_bk2", BKS, 4'd0, '0, mk(32'hFFFFFFF1, 1, 0, 0, 0, 0, 0));
    step("clr2", CLR, 4'd0, '0, mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
    acc = '1;
    for (int k = 1; k <= 8; k++) begin
      acc = {acc[27:0], 4'(k)};
      step("fill", LD, 4'(k), '0, mk(acc, 4'(k), 0, 0, 0, k == 8, 0));
    end
    step("over", LD, 4'd9, '0, mk(32'h12345678, 8, 0, 0, 0, 1, 1));
    step("negfull", NEG, 4'd0, '0, mk(32'h12345678, 8, 0, 0, 0, 1, 1));
    step("errdrop", IDLE, 4'd0, '0, mk(32'h12345678, 8, 0, 0, 0, 1, 0));
    step("clr3", CLR, 4'd0, '0, mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
    step("rcl", MEM, 4'd0, 32'hFFFE0042, mk(32'hFFFE0042, 4, 1, 0, 0, 0, 0));
    step("rcl_ld7", LD, 4'd7, '0, mk(32'hFFFFFFF7, 1, 0, 0, 0, 0, 0));
    step("rcl_bad", MEM, 4'd0, 32'hFFFFA123, mk(32'hFFFFFFF7, 1, 0, 0, 0, 0, 1));
    step("rcl_2min", MEM, 4'd0, 32'hFFEE0012, mk(32'hFFFFFFF7, 1, 0, 0, 0, 0, 1));
    step("rcl_above", MEM, 4'd0, 32'hFF1E2345, mk(32'hFFFFFFF7, 1, 0, 0, 0, 0, 1));
    step("rcl_ok", MEM, 4'd0, 32'hFFFFF123, mk(32'hFFFFF123, 3, 0, 0, 0, 0, 0));
    step("rcl_bk", BKS, 4'd0, '0, mk(32'hFFFFFF12, 2, 0, 0, 0, 0, 0));
    step("rcl_ld4", LD, 4'd4, '0, mk(32'hFFFFF124, 3, 0, 0, 0, 0, 0));
    step("rcl_blank", MEM, 4'd0, 32'hFFFFFFFF, mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
    step("bk_empty", BKS, 4'd0, '0, mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
    step("lz", LD, 4'd0, '0, mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
    step("dp_empty", DPS, 4'd0, '0, mk(32'hFFFFFFF0, 1, 0, 1, 0, 0, 0));
    step("dp_ld0", LD, 4'd0, '0, mk(32'hFFFFFF00, 2, 0, 1, 1, 0, 0));
    step("dp_twice", DPS, 4'd0, '0, mk(32'hFFFFFF00, 2, 0, 1, 1, 0, 1));
    step("bad_dig", LD, 4'hB, '0, mk(32'hFFFFFF00, 2, 0, 1, 1, 0, 1));
    step("clr_ld", CLR | LD, 4'd5, '0, mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
    step("mem_ld", MEM | LD, 4'd9, 32'hFFFFFF12, mk(32'hFFFFFF12, 2, 0, 0, 0, 0, 0));
    step("clr4", CLR, 4'd0, '0, mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
    step("neg_empty", NEG, 4'd0, '0, mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
    step("n_ld3", LD, 4'd3, '0, mk(32'hFFFFFFF3, 1, 0, 0, 0, 0, 0));
    step("n_neg", NEG, 4'd0, '0, mk(32'hFFFFFFE3, 1, 1, 0, 0, 0, 0));
    step("n_bk", BKS, 4'd0, '0, mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
    acc = '1;
    for (int k = 1; k <= 7; k++) begin
      acc = {acc[27:0], 4'(k)};
      step("fill7", LD, 4'(k), '0, mk(acc, 4'(k), 0, 0, 0, 0, 0));
    end
    step("cap_neg", NEG, 4'd0, '0, mk(32'hE1234567, 7, 1, 0, 0, 1, 0));
    step("cap_ld", LD, 4'd8, '0, mk(32'hE1234567, 7, 1, 0, 0, 1, 1));
    step("cap_bk", BKS, 4'd0, '0, mk(32'hFE123456, 6, 1, 0, 0, 0, 0));
    step("clr5", CLR, 4'd0, '0, mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
    step("a_ld1", LD, 4'd1, '0, mk(32'hFFFFFFF1, 1, 0, 0, 0, 0, 0));
    step("a_ld2", LD, 4'd2, '0, mk(32'hFFFFFF12, 2, 0, 0, 0, 0, 0));
    @(negedge clock);
    {clear, load_mem, bksp, neg_toggle, dp_set, load} = IDLE;
    #2;
    reset_n = 1'b0;
    #1;
    check("async/bcd", bcdreg, 32'hFFFFFFFF);
    check("async/count", 32'(count), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step("post_rst", LD, 4'd4, '0, mk(32'hFFFFFFF4, 1, 0, 0, 0, 0, 0));
    @(negedge clock);
    {clear, load_mem, bksp, neg_toggle, dp_set, load} = IDLE;
    @(negedge clock);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
